id_exe_stage: RTL and testbench
===============================

// Module: id_exe_stage
// PURPOSE
//  ID->EXE pipeline register for the bexkat1 pipeline. Consumes hazard1/hazard2
//  from the forwarder, selects each operand (register file, EXE result, MEM
//  result) and latches it with the instruction into the EXE stage. Detects
//  load-use hazards: inserts one bubble and stalls ID. Also handles flush and
//  downstream stall, and counts stall cycles.
// PARAMETERS
//  WIDTH   32        operand / result / pc width
//  NOP_IR  64'h0     instruction word loaded into EXE as a bubble
//  CNT_W   16        width of stall_count_o (saturating)
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_i          in   1      reset, asynchronous, active-low
//  flush_i        in   1      discard ID instruction (branch taken / exception)
//  stall_i        in   1      downstream stall: hold EXE registers
//  id_ir          in   64     decoded instruction in ID
//  id_reg_write   in   2      ID writeback enables (nonzero = writes ra)
//  id_pc          in   WIDTH  ID instruction pc
//  id_reg_data1   in   WIDTH  regfile read of rb
//  id_reg_data2   in   WIDTH  regfile read of rc
//  hazard1        in   2      forwarder code for rb: 0 none, 1 MEM, 2 EXE, 3 none
//  hazard2        in   2      forwarder code for rc, same encoding
//  exe_result_i   in   WIDTH  ALU result of instruction currently in EXE
//  mem_result_i   in   WIDTH  result of instruction currently in MEM
//  exe_mem_read_i in   1      instruction in EXE is a load (result not in exe_result_i)
//  exe_ir         out  64     registered instruction for EXE
//  exe_reg_write  out  2      registered writeback enables
//  exe_pc         out  WIDTH  registered pc
//  exe_data1      out  WIDTH  registered forwarded operand 1 (rb)
//  exe_data2      out  WIDTH  registered forwarded operand 2 (rc)
//  id_stall_o     out  1      combinational: ID/IF must hold this cycle
//  stall_count_o  out  CNT_W  saturating count of cycles with id_stall_o=1
// BEHAVIOUR
//  Reset (rst_i=0, async): exe_ir=NOP_IR, exe_reg_write=0, exe_pc=0,
//   exe_data1/2=0, stall_count_o=0, state=RUN. id_stall_o=0 while in reset.
//  Operand mux (comb): code 1 -> mem_result_i, 2 -> exe_result_i,
//   0/3 -> id_reg_data. Forwarder priority (MEM before EXE) is not redone here.
//  Load-use: lu = exe_mem_read_i & (hazard1==2 | hazard2==2) & state==RUN.
//  States: RUN, LDSTALL.
//   RUN, lu=1, no flush/stall_i: load bubble (exe_ir=NOP_IR, exe_reg_write=0,
//    exe_pc/data unchanged), id_stall_o=1, -> LDSTALL.
//   LDSTALL: never re-detects lu (load is now in MEM, forwarder reports 1);
//    latches ID normally, -> RUN. Exactly one bubble per load-use.
//  Per-edge priority: flush_i > stall_i > lu > normal latch.
//   flush_i=1: bubble into EXE, state=RUN, id_stall_o=0 (ignores stall_i).
//   stall_i=1 (no flush): all EXE regs and state hold; id_stall_o=1.
//   normal: EXE regs <= id_* with muxed operands, 1-cycle latency.
//  id_stall_o = ~flush_i & (stall_i | lu).
//  stall_count_o increments when id_stall_o=1, saturates at all-ones.
//  Bubble has exe_reg_write=0 so forwarder sees no false EXE hazard next cycle.
// TESTING
//  1 Reset mid-run: rst_i low async -> outputs to reset values same cycle,
//    no clock edge needed; stall_count_o=0.
//  2 Forward select: id_reg_data1=1, exe_result_i=2, mem_result_i=3; hazard1
//    0/1/2/3 -> exe_data1 = 1/3/2/1 after next edge; same for hazard2/exe_data2.
//  3 Load-use: exe_mem_read_i=1, hazard2=2 -> id_stall_o=1, next exe_ir=NOP_IR,
//    exe_reg_write=0; following cycle (hazard2=1, mem_result_i=0x55)
//    -> exe_data2=0x55, exactly one bubble, stall_count_o=1.
//  4 flush_i and stall_i together with lu -> bubble, id_stall_o=0, state RUN,
//    counter unchanged.
//  5 stall_i held 3 cycles -> exe_* unchanged, id_stall_o=1, stall_count_o+=3;
//    with CNT_W=2 preloaded to 3 -> stays 3.
//  6 Back-to-back loads each feeding next via EXE -> bubble after each, no
//    double bubble, no lost instruction (compare retired stream to model).

Source files
------------

// File: rtl/id_exe_stage.sv
// id_exe_stage: ID->EXE pipeline register for the bexkat1 pipeline.
// Selects forwarded operands, latches the ID instruction into EXE, inserts a
// single bubble on a load-use hazard, honours flush and downstream stall, and
// keeps a saturating count of cycles in which ID was told to hold.
module id_exe_stage #(
   parameter int          WIDTH  = 32,
   parameter logic [63:0] NOP_IR = 64'h0,
   parameter int          CNT_W  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             stall_i,
   input  logic [63:0]      id_ir,
   input  logic [1:0]       id_reg_write,
   input  logic [WIDTH-1:0] id_pc,
   input  logic [WIDTH-1:0] id_reg_data1,
   input  logic [WIDTH-1:0] id_reg_data2,
   input  logic [1:0]       hazard1,
   input  logic [1:0]       hazard2,
   input  logic [WIDTH-1:0] exe_result_i,
   input  logic [WIDTH-1:0] mem_result_i,
   input  logic             exe_mem_read_i,
   output logic [63:0]      exe_ir,
   output logic [1:0]       exe_reg_write,
   output logic [WIDTH-1:0] exe_pc,
   output logic [WIDTH-1:0] exe_data1,
   output logic [WIDTH-1:0] exe_data2,
   output logic             id_stall_o,
   output logic [CNT_W-1:0] stall_count_o
);

   // Forwarder codes: 1 = value sits in MEM, 2 = value sits in EXE, else regfile.
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_EXE = 2'd2;

   // RUN: normal flow. LDSTALL: the bubble for a load-use has just been
   // issued, so the dependent instruction must now be latched unconditionally.
   typedef enum logic {
      RUN     = 1'b0,
      LDSTALL = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [63:0]      ir_q, ir_d;
   logic [1:0]       rw_q, rw_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] d1_q, d1_d;
   logic [WIDTH-1:0] d2_q, d2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] op1, op2;
   logic             load_use;
   logic             id_stall;
   logic             cnt_full;

   // Operand selection; MEM-vs-EXE priority has already been resolved upstream.
   always_comb begin
      op1 = id_reg_data1;
      op2 = id_reg_data2;
      case (hazard1)
         FWD_MEM: op1 = mem_result_i;
         FWD_EXE: op1 = exe_result_i;
         default: op1 = id_reg_data1;
      endcase
      case (hazard2)
         FWD_MEM: op2 = mem_result_i;
         FWD_EXE: op2 = exe_result_i;
         default: op2 = id_reg_data2;
      endcase
   end

   // A load in EXE has no result on exe_result_i yet, so an EXE-forwarded
   // operand from it is a load-use hazard; in LDSTALL the load has moved on
   // to MEM and the forwarder reports it there instead.
   always_comb begin
      load_use = exe_mem_read_i
                 & ((hazard1 == FWD_EXE) | (hazard2 == FWD_EXE))
                 & (state_q == RUN);
      // Held low during reset; flush overrides any stall request.
      id_stall = rst_i & ~flush_i & (stall_i | load_use);
      cnt_full = &cnt_q;
   end

   assign id_stall_o = id_stall;

   // Next-state / next-register selection in priority flush > stall > load-use > latch.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      rw_d    = rw_q;
      pc_d    = pc_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      if (flush_i) begin
         // Squash: bubble into EXE, pc/data are don't-care and left as is.
         ir_d    = NOP_IR;
         rw_d    = 2'b00;
         state_d = RUN;
      end else if (stall_i) begin
         // Downstream hold: keep everything, including the FSM state.
         state_d = state_q;
      end else if (load_use) begin
         // Bubble carries no write enable so no false EXE hazard appears next cycle.
         ir_d    = NOP_IR;
         rw_d    = 2'b00;
         state_d = LDSTALL;
      end else begin
         ir_d    = id_ir;
         rw_d    = id_reg_write;
         pc_d    = id_pc;
         d1_d    = op1;
         d2_d    = op2;
         state_d = RUN;
      end
   end

   // Saturating stall-cycle counter.
   always_comb begin
      cnt_d = cnt_q;
      if (id_stall && !cnt_full) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // EXE pipeline registers, FSM state and counter.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= RUN;
         ir_q    <= NOP_IR;
         rw_q    <= 2'b00;
         pc_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         rw_q    <= rw_d;
         pc_q    <= pc_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         cnt_q   <= cnt_d;
      end
   end

   assign exe_ir        = ir_q;
   assign exe_reg_write = rw_q;
   assign exe_pc        = pc_q;
   assign exe_data1     = d1_q;
   assign exe_data2     = d2_q;
   assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Self-checking bench for id_exe_stage with a cycle-level behavioural model.
module tb_id_exe_stage;
   localparam int          W   = 32;
   localparam logic [63:0] NOP = 64'hDEAD_0000_0000_BEEF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush, stall, exe_mrd;
   logic [63:0]   id_ir;
   logic [1:0]    id_rw, h1, h2;
   logic [W-1:0]  id_pc, rd1, rd2, exe_res, mem_res;

   logic [63:0]   o_ir, o_ir2;
   logic [1:0]    o_rw, o_rw2;
   logic [W-1:0]  o_pc, o_d1, o_d2, o_pc2, o_d12, o_d22;
   logic          o_stall, o_stall2;
   logic [15:0]   o_cnt;
   logic [1:0]    o_cnt2;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [63:0]  m_ir;
   logic [1:0]   m_rw;
   logic [W-1:0] m_pc, m_d1, m_d2;
   bit           m_after_lu;
   int           m_cnt;

   always #5 clk = ~clk;

   id_exe_stage #(.WIDTH(W), .NOP_IR(NOP), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .stall_i(stall),
      .id_ir(id_ir), .id_reg_write(id_rw), .id_pc(id_pc),
      .id_reg_data1(rd1), .id_reg_data2(rd2), .hazard1(h1), .hazard2(h2),
      .exe_result_i(exe_res), .mem_result_i(mem_res), .exe_mem_read_i(exe_mrd),
      .exe_ir(o_ir), .exe_reg_write(o_rw), .exe_pc(o_pc),
      .exe_data1(o_d1), .exe_data2(o_d2), .id_stall_o(o_stall), .stall_count_o(o_cnt));

   id_exe_stage #(.WIDTH(W), .NOP_IR(NOP), .CNT_W(2)) dut2 (
      .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .stall_i(stall),
      .id_ir(id_ir), .id_reg_write(id_rw), .id_pc(id_pc),
      .id_reg_data1(rd1), .id_reg_data2(rd2), .hazard1(h1), .hazard2(h2),
      .exe_result_i(exe_res), .mem_result_i(mem_res), .exe_mem_read_i(exe_mrd),
      .exe_ir(o_ir2), .exe_reg_write(o_rw2), .exe_pc(o_pc2),
      .exe_data1(o_d12), .exe_data2(o_d22), .id_stall_o(o_stall2), .stall_count_o(o_cnt2));

   function automatic logic [W-1:0] fwd(input logic [1:0] h, input logic [W-1:0] rf);
      if (h == 2'd1) return mem_res;
      if (h == 2'd2) return exe_res;
      return rf;
   endfunction

   function automatic logic exp_stall();
      logic lu;
      lu = exe_mrd && (h1 == 2'd2 || h2 == 2'd2) && !m_after_lu;
      return rst_n && !flush && (stall || lu);
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_ir = NOP; m_rw = 0; m_pc = 0; m_d1 = 0; m_d2 = 0;
      m_after_lu = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      logic st, lu;
      st = exp_stall();
      lu = exe_mrd && (h1 == 2'd2 || h2 == 2'd2) && !m_after_lu;
      if (st) m_cnt++;
      if (flush) begin
         m_ir = NOP; m_rw = 0; m_after_lu = 0;
      end else if (stall) begin
         // everything holds
      end else if (lu) begin
         m_ir = NOP; m_rw = 0; m_after_lu = 1;
      end else begin
         m_ir = id_ir; m_rw = id_rw; m_pc = id_pc;
         m_d1 = fwd(h1, rd1); m_d2 = fwd(h2, rd2);
         m_after_lu = 0;
      end
   endtask

   // Advances model and DUT by one clock edge; samples 1 time unit after the edge.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      flush = 0; stall = 0; exe_mrd = 0; h1 = 0; h2 = 0;
   endtask

   task automatic rand_inputs();
      id_ir   = {$urandom, $urandom};
      id_rw   = 2'($urandom_range(0, 3));
      id_pc   = $urandom; rd1 = $urandom; rd2 = $urandom;
      exe_res = $urandom; mem_res = $urandom;
      h1      = 2'($urandom_range(0, 3));
      h2      = 2'($urandom_range(0, 3));
      exe_mrd = ($urandom_range(0, 2) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      stall   = ($urandom_range(0, 5) == 0);
   endtask

   task automatic test_reset_initial();
      checks++;
      if (o_ir !== NOP || o_rw !== 2'b00 || o_pc !== '0 || o_d1 !== '0 || o_d2 !== '0) begin
         errors++;
         $display("FAIL reset_regs ir=%h rw=%0d pc=%h d1=%h d2=%h required ir=%h rest 0",
                  o_ir, o_rw, o_pc, o_d1, o_d2, NOP);
      end
      checks++;
      if (o_cnt !== 16'd0 || o_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt_stall cnt=%0d stall=%b required 0 0", o_cnt, o_stall);
      end
   endtask

   task automatic test_reset_midrun();
      // Mid-cycle assertion with a stall request pending
      stall = 1; exe_mrd = 1; h2 = 2;
      #2 rst_n = 0;
      #1;
      checks++;
      if (o_ir !== NOP || o_rw !== 2'b00 || o_pc !== '0 || o_d1 !== '0 || o_d2 !== '0) begin
         errors++;
         $display("FAIL reset_async_regs ir=%h rw=%0d pc=%h d1=%h d2=%h required ir=%h rest 0",
                  o_ir, o_rw, o_pc, o_d1, o_d2, NOP);
      end
      checks++;
      if (o_cnt !== 16'd0 || o_cnt2 !== 2'd0) begin
         errors++;
         $display("FAIL reset_async_cnt cnt=%0d cnt2=%0d required 0 0", o_cnt, o_cnt2);
      end
      checks++;
      if (o_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_async_stall stall=%b required 0", o_stall);
      end
      model_reset();
      #3 rst_n = 1;
      quiet_inputs();
      tick();
   endtask

   task automatic test_forward();
      logic [W-1:0] expv [4];
      expv = '{32'd1, 32'd3, 32'd2, 32'd1};
      quiet_inputs();
      rd1 = 1; rd2 = 1; exe_res = 2; mem_res = 3;
      for (int h = 0; h < 4; h++) begin
         h1 = 2'(h); h2 = 2'd0;
         tick();
         checks++;
         if (o_d1 !== expv[h] || o_d1 !== m_d1) begin
            errors++;
            $display("FAIL fwd1_h%0d data1=%0d required %0d", h, o_d1, expv[h]);
         end
      end
      for (int h = 0; h < 4; h++) begin
         h1 = 2'd0; h2 = 2'(h);
         tick();
         checks++;
         if (o_d2 !== expv[h] || o_d2 !== m_d2) begin
            errors++;
            $display("FAIL fwd2_h%0d data2=%0d required %0d", h, o_d2, expv[h]);
         end
      end
   endtask

   task automatic test_load_use();
      logic [63:0] a;
      int c0;
      quiet_inputs();
      tick();
      c0 = m_cnt;
      a = 64'h0123_4567_89AB_CDEF;
      id_ir = a; id_rw = 2'b01; exe_mrd = 1; h1 = 0; h2 = 2;
      #1;
      checks++;
      if (o_stall !== 1'b1) begin
         errors++; $display("FAIL lu_stall stall=%b required 1", o_stall);
      end
      tick();
      checks++;
      if (o_ir !== NOP || o_rw !== 2'b00 || o_cnt !== 16'(c0 + 1)) begin
         errors++;
         $display("FAIL lu_bubble ir=%h rw=%0d cnt=%0d required ir=%h rw=0 cnt=%0d",
                  o_ir, o_rw, o_cnt, NOP, c0 + 1);
      end
      exe_mrd = 0; h2 = 1; mem_res = 32'h55;
      #1;
      checks++;
      if (o_stall !== 1'b0) begin
         errors++; $display("FAIL lu_release stall=%b required 0", o_stall);
      end
      tick();
      checks++;
      if (o_d2 !== 32'h55 || o_ir !== a || o_rw !== 2'b01 || o_cnt !== 16'(c0 + 1)) begin
         errors++;
         $display("FAIL lu_latch d2=%h ir=%h rw=%0d cnt=%0d required d2=55 ir=%h rw=1 cnt=%0d",
                  o_d2, o_ir, o_rw, o_cnt, a, c0 + 1);
      end
      // Second hazard; in the following cycle an EXE-load code must not re-stall
      exe_mrd = 1; h2 = 2;
      tick();
      #1;
      checks++;
      if (o_stall !== 1'b0) begin
         errors++; $display("FAIL lu_no_double stall=%b required 0", o_stall);
      end
      tick();
      checks++;
      if (o_ir !== id_ir || o_cnt !== 16'(m_cnt)) begin
         errors++;
         $display("FAIL lu_no_double_latch ir=%h cnt=%0d required ir=%h cnt=%0d",
                  o_ir, o_cnt, id_ir, m_cnt);
      end
      quiet_inputs();
      tick();
   endtask

   task automatic test_flush_stall();
      int c0;
      quiet_inputs();
      tick();
      c0 = m_cnt;
      id_rw = 2'b11; exe_mrd = 1; h2 = 2; flush = 1; stall = 1;
      #1;
      checks++;
      if (o_stall !== 1'b0) begin
         errors++; $display("FAIL flush_stall_out stall=%b required 0", o_stall);
      end
      tick();
      checks++;
      if (o_ir !== NOP || o_rw !== 2'b00 || o_cnt !== 16'(c0)) begin
         errors++;
         $display("FAIL flush_bubble ir=%h rw=%0d cnt=%0d required ir=%h rw=0 cnt=%0d",
                  o_ir, o_rw, o_cnt, NOP, c0);
      end
      flush = 0; stall = 0;
      #1;
      checks++;
      if (o_stall !== 1'b1) begin
         errors++; $display("FAIL flush_state_run stall=%b required 1", o_stall);
      end
      quiet_inputs();
      tick();
   endtask

   task automatic test_stall_hold();
      logic [63:0]  sir;
      logic [1:0]   srw;
      logic [W-1:0] spc, sd1, sd2;
      int c0;
      rand_inputs();
      flush = 0; stall = 0; exe_mrd = 0;
      tick();
      sir = o_ir; srw = o_rw; spc = o_pc; sd1 = o_d1; sd2 = o_d2;
      c0 = m_cnt;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         flush = 0; stall = 1;
         #1;
         checks++;
         if (o_stall !== 1'b1) begin
            errors++; $display("FAIL hold_stall_%0d stall=%b required 1", i, o_stall);
         end
         tick();
         checks++;
         if (o_ir !== sir || o_rw !== srw || o_pc !== spc || o_d1 !== sd1 || o_d2 !== sd2) begin
            errors++;
            $display("FAIL hold_regs_%0d ir=%h pc=%h d1=%h d2=%h required ir=%h pc=%h d1=%h d2=%h",
                     i, o_ir, o_pc, o_d1, o_d2, sir, spc, sd1, sd2);
         end
      end
      checks++;
      if (o_cnt !== 16'(c0 + 3)) begin
         errors++; $display("FAIL hold_cnt cnt=%0d required %0d", o_cnt, c0 + 3);
      end
      checks++;
      if (o_cnt2 !== 2'(sat(c0 + 3, 3))) begin
         errors++; $display("FAIL hold_cnt_sat cnt2=%0d required %0d", o_cnt2, sat(c0 + 3, 3));
      end
      quiet_inputs();
      tick();
   endtask

   task automatic test_back_to_back();
      localparam int N = 6;
      logic [63:0] prog [N];
      logic [63:0] retired [$];
      int idx, bubbles, cyc;
      bit adv;
      for (int i = 0; i < N; i++) prog[i] = {32'hA000_0000 + 32'(i), $urandom};
      quiet_inputs();
      flush = 1;
      tick();
      flush = 0;
      idx = 0; bubbles = 0; cyc = 0;
      while (retired.size() < N && cyc < 4 * N) begin
         id_ir   = (idx < N) ? prog[idx] : NOP;
         id_rw   = (idx < N) ? 2'b01 : 2'b00;
         id_pc   = 32'(idx);
         exe_res = $urandom; mem_res = $urandom; rd2 = $urandom;
         // Each instruction reads the previous load's result
         exe_mrd = (m_ir != NOP);
         h2      = (m_ir != NOP) ? 2'd2 : 2'd1;
         #1;
         adv = !exp_stall();
         checks++;
         if (o_stall !== exp_stall()) begin
            errors++; $display("FAIL b2b_stall_c%0d stall=%b required %b", cyc, o_stall, exp_stall());
         end
         tick();
         checks++;
         if (o_ir !== m_ir || o_d2 !== m_d2) begin
            errors++;
            $display("FAIL b2b_regs_c%0d ir=%h d2=%h required ir=%h d2=%h", cyc, o_ir, o_d2, m_ir, m_d2);
         end
         if (o_ir !== NOP) retired.push_back(o_ir);
         else bubbles++;
         if (adv && idx < N) idx++;
         cyc++;
      end
      checks++;
      if (retired.size() != N) begin
         errors++; $display("FAIL b2b_count retired=%0d required %0d", retired.size(), N);
      end
      for (int i = 0; i < N && i < retired.size(); i++) begin
         checks++;
         if (retired[i] !== prog[i]) begin
            errors++; $display("FAIL b2b_order_%0d ir=%h required %h", i, retired[i], prog[i]);
         end
      end
      checks++;
      if (bubbles != N - 1) begin
         errors++; $display("FAIL b2b_bubbles bubbles=%0d required %0d", bubbles, N - 1);
      end
      quiet_inputs();
      tick();
   endtask

   task automatic test_random(input int n);
      for (int i = 0; i < n; i++) begin
         rand_inputs();
         #1;
         checks++;
         if (o_stall !== exp_stall()) begin
            errors++; $display("FAIL rand_stall_%0d stall=%b required %b", i, o_stall, exp_stall());
         end
         tick();
         checks++;
         if (o_ir !== m_ir || o_rw !== m_rw || o_pc !== m_pc || o_d1 !== m_d1 || o_d2 !== m_d2) begin
            errors++;
            $display("FAIL rand_regs_%0d ir=%h rw=%0d pc=%h d1=%h d2=%h required ir=%h rw=%0d pc=%h d1=%h d2=%h",
                     i, o_ir, o_rw, o_pc, o_d1, o_d2, m_ir, m_rw, m_pc, m_d1, m_d2);
         end
         checks++;
         if (o_cnt !== 16'(sat(m_cnt, 65535)) || o_cnt2 !== 2'(sat(m_cnt, 3))) begin
            errors++;
            $display("FAIL rand_cnt_%0d cnt=%0d cnt2=%0d required %0d %0d",
                     i, o_cnt, o_cnt2, sat(m_cnt, 65535), sat(m_cnt, 3));
         end
      end
      quiet_inputs();
   endtask

   initial begin
      rst_n = 0;
      quiet_inputs();
      id_ir = 0; id_rw = 0; id_pc = 0; rd1 = 0; rd2 = 0; exe_res = 0; mem_res = 0;
      model_reset();
      #12;
      test_reset_initial();
      rst_n = 1;
      tick();
      test_forward();
      test_load_use();
      test_flush_stall();
      test_stall_hold();
      test_back_to_back();
      test_random(300);
      test_reset_midrun();
      test_random(60);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
